// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  localparam int OVERSAMPLE = 32'sd16;

  // Rounded clocks-per-oversample-tick, never below one.
  function automatic int baud_div(input int clk_hz, input int baud);
    int div;
    div = (clk_hz + (OVERSAMPLE * baud) / 32'sd2) / (OVERSAMPLE * baud);
    if (div < 32'sd1) begin
      div = 32'sd1;
    end else begin
      div = div;
    end
    return div;
  endfunction

  // Expected parity bit for data (unused upper bits must be zero).
  function automatic logic parity_of(input logic [7:0] data, input parity_e mode);
    logic p;
    case (mode)
      PAR_ODD:  p = ~(^data);
      PAR_EVEN: p = ^data;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered head data, occupancy and overflow detect.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     not_empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow_evt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] ZERO_LVL = {LVL_W{1'b0}};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] count_r;
  logic [WIDTH-1:0] head_r;
  logic             not_empty_r;

  logic             pop_ok_s;
  logic             push_ok_s;
  logic [LVL_W-1:0] after_pop_s;
  logic [LVL_W-1:0] count_next_s;
  logic [PTR_W-1:0] rd_ptr_next_s;
  logic [WIDTH-1:0] head_next_s;

  // A push into a full FIFO only succeeds when a pop frees a slot that cycle.
  always_comb begin
    pop_ok_s      = pop && (count_r != ZERO_LVL);
    push_ok_s     = push && ((count_r != FULL_LVL) || pop_ok_s);
    overflow_evt  = push && (count_r == FULL_LVL) && !pop_ok_s;
    after_pop_s   = count_r - LVL_W'(pop_ok_s);
    count_next_s  = after_pop_s + LVL_W'(push_ok_s);
    rd_ptr_next_s = pop_ok_s ? (rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1}) : rd_ptr_r;
    if (count_next_s == ZERO_LVL) begin
      head_next_s = head_r;
    end else if (after_pop_s == ZERO_LVL) begin
      head_next_s = push_data;
    end else begin
      head_next_s = mem_r[rd_ptr_next_s];
    end
  end

  // Storage, pointers and the registered head/occupancy view.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= ZERO_LVL;
      head_r      <= {WIDTH{1'b0}};
      not_empty_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      rd_ptr_r    <= rd_ptr_next_s;
      count_r     <= count_next_s;
      head_r      <= head_next_s;
      not_empty_r <= (count_next_s != ZERO_LVL);
    end
  end

  assign head_data = head_r;
  assign not_empty = not_empty_r;
  assign level     = count_r;

endmodule

// File: rtl/uart_rx_fifo.sv
// 16x oversampling UART receiver (configurable frame format) feeding a
// receive FIFO, with sticky framing/parity/overflow flags.
module uart_rx_fifo #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overflow,
  input  logic                          err_clr
);
  import uart_pkg::*;

  localparam int DIV   = baud_div(CLK_FREQ_HZ, BAUD);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);
  localparam parity_e          PAR_MODE  = parity_e'(2'(PARITY));
  localparam logic [3:0]       PH_S0  = 4'd7;
  localparam logic [3:0]       PH_S1  = 4'd8;
  localparam logic [3:0]       PH_MID = 4'd9;
  localparam logic [3:0]       PH_END = 4'd15;

  rx_state_e            state_r;
  rx_state_e            state_next_s;
  logic [1:0]           sync_r;
  logic                 rx_prev_r;
  logic [CNT_W-1:0]     tick_cnt_r;
  logic [3:0]           phase_r;
  logic [1:0]           smp_r;
  logic [3:0]           bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 stop_bad_r;
  logic                 push_r;
  logic [DATA_BITS-1:0] push_data_r;
  logic                 frame_err_r;
  logic                 parity_err_r;
  logic                 overflow_r;

  logic rx_s, rx_fall_s, start_edge_s, tick_s, mid_s, bit_end_s, bit_s;
  logic shift_en_s, par_chk_s, stop_smp_s, last_stop_s;
  logic parity_set_s, frame_set_s, push_s, ovf_evt_s;

  // Two-flop synchronizer plus a history flop for falling-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r    <= 2'b11;
      rx_prev_r <= 1'b1;
    end else begin
      sync_r    <= {sync_r[0], rx};
      rx_prev_r <= sync_r[1];
    end
  end

  assign rx_s         = sync_r[1];
  assign rx_fall_s    = rx_prev_r & ~rx_s;
  assign start_edge_s = (state_r == RX_IDLE) && rx_fall_s;
  assign tick_s       = (tick_cnt_r == DIV_LAST);

  // Oversample tick divider, realigned to the detected start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_r <= {CNT_W{1'b0}};
    end else if (start_edge_s || tick_s) begin
      tick_cnt_r <= {CNT_W{1'b0}};
    end else begin
      tick_cnt_r <= tick_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Tick position within the bit and the first two of the three mid-bit samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_r <= 4'd0;
      smp_r   <= 2'b00;
    end else if (start_edge_s) begin
      phase_r <= 4'd0;
      smp_r   <= 2'b00;
    end else if (tick_s) begin
      phase_r <= phase_r + 4'd1;
      if (phase_r == PH_S0) begin
        smp_r[0] <= rx_s;
      end else if (phase_r == PH_S1) begin
        smp_r[1] <= rx_s;
      end
    end
  end

  assign mid_s     = tick_s && (phase_r == PH_MID);
  assign bit_end_s = tick_s && (phase_r == PH_END);
  // Third sample is the live synchronized line at the mid tick.
  assign bit_s     = (smp_r[0] & smp_r[1]) | (smp_r[0] & rx_s) | (smp_r[1] & rx_s);

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= RX_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state; the final stop bit hands back to IDLE at its mid sample.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RX_IDLE: begin
        if (rx_fall_s) state_next_s = RX_START;
        else           state_next_s = RX_IDLE;
      end
      RX_START: begin
        if (mid_s && bit_s)  state_next_s = RX_IDLE;
        else if (bit_end_s)  state_next_s = RX_DATA;
        else                 state_next_s = RX_START;
      end
      RX_DATA: begin
        if (bit_end_s && (bit_cnt_r == LAST_DATA))
          state_next_s = (PAR_MODE != PAR_NONE) ? RX_PARITY : RX_STOP;
        else
          state_next_s = RX_DATA;
      end
      RX_PARITY: begin
        if (bit_end_s) state_next_s = RX_STOP;
        else           state_next_s = RX_PARITY;
      end
      RX_STOP: begin
        if (mid_s && (bit_cnt_r == LAST_STOP)) state_next_s = RX_IDLE;
        else                                   state_next_s = RX_STOP;
      end
      default: state_next_s = RX_IDLE;
    endcase
  end

  // FSM outputs: per-state sample strobes.
  always_comb begin
    shift_en_s  = 1'b0;
    par_chk_s   = 1'b0;
    stop_smp_s  = 1'b0;
    last_stop_s = 1'b0;
    case (state_r)
      RX_DATA:   shift_en_s = mid_s;
      RX_PARITY: par_chk_s  = mid_s;
      RX_STOP: begin
        stop_smp_s  = mid_s;
        last_stop_s = mid_s && (bit_cnt_r == LAST_STOP);
      end
      default: shift_en_s = 1'b0;
    endcase
  end

  assign parity_set_s = par_chk_s && (bit_s != parity_of(8'(shift_r), PAR_MODE));
  assign frame_set_s  = stop_smp_s && !bit_s;
  assign push_s       = last_stop_s && bit_s && !stop_bad_r;

  // Bit counter, LSB-first shifter and per-frame bad-stop memory.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_r  <= 4'd0;
      shift_r    <= {DATA_BITS{1'b0}};
      stop_bad_r <= 1'b0;
    end else begin
      if (state_r != state_next_s) begin
        bit_cnt_r <= 4'd0;
      end else if (bit_end_s) begin
        bit_cnt_r <= bit_cnt_r + 4'd1;
      end
      if (shift_en_s) begin
        shift_r <= {bit_s, shift_r[DATA_BITS-1:1]};
      end
      if (state_r == RX_START) begin
        stop_bad_r <= 1'b0;
      end else if (frame_set_s) begin
        stop_bad_r <= 1'b1;
      end
    end
  end

  // Push strobe lands one cycle after the final stop sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      push_r      <= 1'b0;
      push_data_r <= {DATA_BITS{1'b0}};
    end else begin
      push_r <= push_s;
      if (push_s) begin
        push_data_r <= shift_r;
      end
    end
  end

  // Sticky error flags; a clear outranks a same-cycle set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else if (err_clr) begin
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      if (frame_set_s)  frame_err_r  <= 1'b1;
      if (parity_set_s) parity_err_r <= 1'b1;
      if (ovf_evt_s)    overflow_r   <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .push         (push_r),
    .push_data    (push_data_r),
    .pop          (rd_ready),
    .head_data    (rd_data),
    .not_empty    (rd_valid),
    .level        (level),
    .overflow_evt (ovf_evt_s)
  );

  assign frame_err  = frame_err_r;
  assign parity_err = parity_err_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: three receiver configurations driven over a shared serial source.
module tb_uart_rx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic rx_line = 1'b1;
  int   sel     = 0;
  logic rx_a, rx_b, rx_c;
  assign rx_a = (sel == 0) ? rx_line : 1'b1;
  assign rx_b = (sel == 1) ? rx_line : 1'b1;
  assign rx_c = (sel == 2) ? rx_line : 1'b1;

  logic rst_a_n = 1'b0, rst_b_n = 1'b0, rst_c_n = 1'b0;
  logic rdy_a = 1'b0, rdy_b = 1'b0, rdy_c = 1'b0;
  logic clr = 1'b0;

  logic [7:0] rd_data_a;  logic rd_valid_a; logic [4:0] level_a;
  logic fe_a, pe_a, ov_a;
  logic [6:0] rd_data_b;  logic rd_valid_b; logic [4:0] level_b;
  logic fe_b, pe_b, ov_b;
  logic [7:0] rd_data_c;  logic rd_valid_c; logic [2:0] level_c;
  logic fe_c, pe_c, ov_c;

  uart_rx_fifo dut_a (
    .clk(clk), .reset_n(rst_a_n), .rx(rx_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .rd_ready(rdy_a), .level(level_a), .frame_err(fe_a), .parity_err(pe_a),
    .overflow(ov_a), .err_clr(clr)
  );

  uart_rx_fifo #(.CLK_FREQ_HZ(7_372_800), .DATA_BITS(7), .PARITY(2)) dut_b (
    .clk(clk), .reset_n(rst_b_n), .rx(rx_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .rd_ready(rdy_b), .level(level_b), .frame_err(fe_b), .parity_err(pe_b),
    .overflow(ov_b), .err_clr(clr)
  );

  uart_rx_fifo #(.CLK_FREQ_HZ(7_372_800), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .reset_n(rst_c_n), .rx(rx_c), .rd_data(rd_data_c), .rd_valid(rd_valid_c),
    .rd_ready(rdy_c), .level(level_c), .frame_err(fe_c), .parity_err(pe_c),
    .overflow(ov_c), .err_clr(clr)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One frame: start, nbits data LSB first, optional parity, one stop bit.
  task automatic send_frame(input int s, input logic [7:0] data, input int nbits,
                            input bit par_en, input logic par_bit, input logic stop_bit,
                            input int bitc);
    sel = s;
    @(negedge clk);
    rx_line = 1'b0;
    repeat (bitc) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx_line = data[i];
      repeat (bitc) @(negedge clk);
    end
    if (par_en) begin
      rx_line = par_bit;
      repeat (bitc) @(negedge clk);
    end
    rx_line = stop_bit;
    repeat (bitc) @(negedge clk);
    rx_line = 1'b1;
  endtask

  task automatic pop_one(input int s, input logic [7:0] exp, input string tag);
    @(negedge clk);
    case (s)
      0: begin
        check_val({tag, "_valid"}, 32'(rd_valid_a), 32'd1);
        check_val({tag, "_data"}, 32'(rd_data_a), 32'(exp));
        rdy_a = 1'b1;
      end
      1: begin
        check_val({tag, "_valid"}, 32'(rd_valid_b), 32'd1);
        check_val({tag, "_data"}, 32'(rd_data_b), 32'(exp));
        rdy_b = 1'b1;
      end
      default: begin
        check_val({tag, "_valid"}, 32'(rd_valid_c), 32'd1);
        check_val({tag, "_data"}, 32'(rd_data_c), 32'(exp));
        rdy_c = 1'b1;
      end
    endcase
    @(negedge clk);
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    rdy_c = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int  cyc;
    bit  seen;
    repeat (3) @(negedge clk);
    check_val("rst_valid_a", 32'(rd_valid_a), 32'd0);
    check_val("rst_level_a", 32'(level_a), 32'd0);
    check_val("rst_data_a", 32'(rd_data_a), 32'd0);
    check_val("rst_flags_a", 32'({fe_a, pe_a, ov_a}), 32'd0);
    check_val("rst_level_c", 32'(level_c), 32'd0);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    rst_c_n = 1'b1;
    repeat (5) @(negedge clk);

    // 0x41 8N1 at DIV=27: last stop sample follows E4160, rd_valid after E4162.
    fork
      send_frame(0, 8'h41, 8, 1'b0, 1'b0, 1'b1, 432);
      begin
        cyc  = 0;
        seen = 1'b0;
        @(negedge clk);
        while (!seen && cyc < 6000) begin
          @(posedge clk);
          #1;
          cyc++;
          seen = rd_valid_a;
        end
        check_val("latency_a", 32'(cyc), 32'd4162);
      end
    join
    check_val("a41_data", 32'(rd_data_a), 32'h41);
    check_val("a41_level", 32'(level_a), 32'd1);
    check_val("a41_flags", 32'({fe_a, pe_a, ov_a}), 32'd0);
    pop_one(0, 8'h41, "a41_pop");
    check_val("a41_empty", 32'(level_a), 32'd0);

    // Stop bit low on 0x55: discarded, frame_err set; 0xAA then lands normally.
    send_frame(0, 8'h55, 8, 1'b0, 1'b0, 1'b0, 432);
    repeat (864) @(negedge clk);
    check_val("fe_flag", 32'(fe_a), 32'd1);
    check_val("fe_level", 32'(level_a), 32'd0);
    send_frame(0, 8'hAA, 8, 1'b0, 1'b0, 1'b1, 432);
    check_val("aa_data", 32'(rd_data_a), 32'hAA);
    check_val("aa_level", 32'(level_a), 32'd1);
    check_val("fe_sticky", 32'(fe_a), 32'd1);
    pulse_clr();
    check_val("fe_clr", 32'(fe_a), 32'd0);
    pop_one(0, 8'hAA, "aa_pop");

    // 100-cycle low glitch on an idle line is rejected silently.
    @(negedge clk);
    rx_line = 1'b0;
    repeat (100) @(negedge clk);
    rx_line = 1'b1;
    repeat (1000) @(negedge clk);
    check_val("glitch_level", 32'(level_a), 32'd0);
    check_val("glitch_flags", 32'({fe_a, pe_a, ov_a}), 32'd0);

    // Reset mid-frame empties the FIFO; the next frame is clean.
    send_frame(0, 8'h33, 8, 1'b0, 1'b0, 1'b1, 432);
    check_val("pre_rst_level", 32'(level_a), 32'd1);
    @(negedge clk);
    rx_line = 1'b0;
    repeat (700) @(negedge clk);
    rst_a_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("midrst_level", 32'(level_a), 32'd0);
    check_val("midrst_valid", 32'(rd_valid_a), 32'd0);
    rx_line = 1'b1;
    rst_a_n = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(0, 8'h7E, 8, 1'b0, 1'b0, 1'b1, 432);
    check_val("r7e_data", 32'(rd_data_a), 32'h7E);
    check_val("r7e_level", 32'(level_a), 32'd1);
    check_val("r7e_flags", 32'({fe_a, pe_a, ov_a}), 32'd0);

    // 7E1: 0x35 has four ones, so the good even-parity bit is 0.
    send_frame(1, 8'h35, 7, 1'b1, 1'b0, 1'b1, 64);
    check_val("par_ok_level", 32'(level_b), 32'd1);
    check_val("par_ok_flag", 32'(pe_b), 32'd0);
    check_val("par_ok_data", 32'(rd_data_b), 32'h35);
    send_frame(1, 8'h35, 7, 1'b1, 1'b1, 1'b1, 64);
    check_val("par_bad_level", 32'(level_b), 32'd2);
    check_val("par_bad_flag", 32'(pe_b), 32'd1);
    check_val("par_bad_fe", 32'(fe_b), 32'd0);
    pulse_clr();
    check_val("par_clr", 32'(pe_b), 32'd0);
    pop_one(1, 8'h35, "par_pop0");
    pop_one(1, 8'h35, "par_pop1");

    // Depth-4 FIFO, no reader: fifth character overflows and is dropped.
    for (int i = 1; i <= 5; i++) begin
      send_frame(2, 8'(i), 8, 1'b0, 1'b0, 1'b1, 64);
    end
    check_val("ovf_level", 32'(level_c), 32'd4);
    check_val("ovf_flag", 32'(ov_c), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      pop_one(2, 8'(i), "ovf_drain");
    end
    @(negedge clk);
    check_val("ovf_no5", 32'(rd_valid_c), 32'd0);
    pulse_clr();
    check_val("ovf_clr", 32'(ov_c), 32'd0);

    // Full FIFO with a pop on the push edge (E620 at DIV=4): push is kept.
    for (int i = 0; i < 4; i++) begin
      send_frame(2, 8'h11 + 8'(i), 8, 1'b0, 1'b0, 1'b1, 64);
    end
    check_val("full_level", 32'(level_c), 32'd4);
    fork
      send_frame(2, 8'h15, 8, 1'b0, 1'b0, 1'b1, 64);
      begin
        @(negedge clk);
        repeat (619) @(negedge clk);
        rdy_c = 1'b1;
        @(negedge clk);
        rdy_c = 1'b0;
      end
    join
    check_val("pp_level", 32'(level_c), 32'd4);
    check_val("pp_ovf", 32'(ov_c), 32'd0);
    for (int i = 0; i < 4; i++) begin
      pop_one(2, 8'h12 + 8'(i), "pp_drain");
    end
    @(negedge clk);
    check_val("pp_empty", 32'(rd_valid_c), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
